// File: rtl/alu_wb_stage.sv
// alu_wb_stage: aligns ALU results with late status flags, resolves branches, emits writeback beats
module alu_wb_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5,
    parameter int Z_IDX = 0,
    parameter int N_IDX = 1,
    parameter int C_IDX = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_alu_r,
    input  logic [2:0]       i_stats,
    input  logic [RD_W-1:0]  i_rd,
    input  logic             i_wr_en,
    input  logic             i_is_br,
    input  logic [2:0]       i_cond,
    input  logic [WIDTH-1:0] i_target,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic             o_wb_en,
    output logic [RD_W-1:0]  o_wb_rd,
    output logic [WIDTH-1:0] o_wb_data,
    output logic             o_br_valid,
    output logic [WIDTH-1:0] o_br_target,
    output logic             o_flush
);
    logic             s1_valid;
    logic             s1_fpend;
    logic             s1_wr_en;
    logic             s1_is_br;
    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s1_target;
    logic [RD_W-1:0]  s1_rd;
    logic [2:0]       s1_cond;
    logic [2:0]       s1_flags;
    logic [2:0]       flags;
    logic             adv;
    logic             accept;
    logic             hit;
    logic             take;

    // Flags come live from i_stats during the flag cycle, else from the held copy; cond[0] inverts the test
    always_comb begin
        flags   = s1_fpend ? i_stats : s1_flags;
        adv     = s1_valid && (!o_wb_valid || i_wb_ready);
        o_ready = !s1_valid || adv;
        accept  = i_valid && o_ready;
        hit     = (s1_cond[2:1] == 2'd0) ? 1'b0 :
                  (s1_cond[2:1] == 2'd1) ? flags[Z_IDX] :
                  (s1_cond[2:1] == 2'd2) ? flags[N_IDX] : flags[C_IDX];
        take    = adv && s1_is_br && (hit ^ s1_cond[0]);
    end

    // S1 occupancy; a taken branch leaving S1 drops whatever is accepted alongside it
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_valid <= 1'b0;
            s1_fpend <= 1'b0;
        end else begin
            s1_valid <= (accept && !take) || (s1_valid && !adv);
            s1_fpend <= accept && !take;
        end
    end

    // S1 payload, plus the one-shot capture of flags in the cycle after accept
    always_ff @(posedge i_clk) begin
        if (accept) begin
            s1_r      <= i_alu_r;
            s1_rd     <= i_rd;
            s1_wr_en  <= i_wr_en;
            s1_is_br  <= i_is_br;
            s1_cond   <= i_cond;
            s1_target <= i_target;
        end
        if (s1_fpend)
            s1_flags <= i_stats;
    end

    // S2 writeback register and single-cycle redirect pulse
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_wb_valid  <= 1'b0;
            o_wb_en     <= 1'b0;
            o_wb_rd     <= '0;
            o_wb_data   <= '0;
            o_br_valid  <= 1'b0;
            o_br_target <= '0;
            o_flush     <= 1'b0;
        end else begin
            o_br_valid <= take;
            o_flush    <= take;
            if (take)
                o_br_target <= s1_target;
            if (adv) begin
                o_wb_valid <= 1'b1;
                o_wb_en    <= s1_wr_en && (s1_rd != '0);
                o_wb_rd    <= s1_rd;
                o_wb_data  <= s1_r;
            end else if (i_wb_ready) begin
                o_wb_valid <= 1'b0;
                o_wb_en    <= 1'b0;
            end
        end
    end
endmodule
